// File: rtl/bpu_ram_ctrl.sv
// bpu_ram_ctrl
// Arbitrates lookup reads and update writes onto one single-port RAM with a
// 1-cycle read latency. Writes go through a one-entry buffer. Reads have
// priority over the buffered write until the write has lost STARVE
// arbitrations in a row; then reads are held off for one cycle so the write
// can issue. A read that hits the still-buffered address returns the
// buffered data (forwarding).
//
// Optional feature macro: BPU_RAM_INIT_EN
//   defined   : after reset the block sweeps addresses 0..DEPTH-1, writing
//               zeros. Reads and writes are refused until the sweep ends.
//   undefined : reset goes straight to RUN and no clearing writes happen.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   rd_req/rd_addr      lookup read request; rd_ready is the accept
//   rd_valid/rd_data    read response, exactly one cycle after accept
//   wr_req/wr_addr/...  update write request; wr_ready is the accept
//   ram_*               single-port RAM interface (read data 1 cycle later)
//   init_done           high while the block is operational
//   dbg_state           current FSM state (1 = RUN), for observation only
//
// Handshake: a request transfers in a cycle where req and ready are both
// high. ready never depends on req of the same channel. A requester may
// drop or change an unaccepted request freely.
module bpu_ram_ctrl #(
  parameter int DATA   = 72,
  parameter int ADDR   = 9,
  parameter int DEPTH  = 2**ADDR,
  parameter int STARVE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [ADDR-1:0] rd_addr,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [DATA-1:0] rd_data,
  input  logic            wr_req,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [DATA-1:0] wr_data,
  output logic            wr_ready,
  output logic [ADDR-1:0] ram_addr,
  output logic            ram_chip_en,
  output logic            ram_write_en,
  output logic [DATA-1:0] ram_write_data,
  input  logic [DATA-1:0] ram_read_data,
  output logic            init_done,
  output logic            dbg_state
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

`ifdef BPU_RAM_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = RUN;
`endif

  state_t          state_q, state_d;
  logic [ADDR-1:0] sweep_q, sweep_d;
  logic            buf_v_q, buf_v_d;
  logic [ADDR-1:0] buf_addr_q, buf_addr_d;
  logic [DATA-1:0] buf_data_q, buf_data_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rd_valid_q, rd_valid_d;
  logic            fwd_q, fwd_d;
  logic [DATA-1:0] fwd_data_q, fwd_data_d;

  logic live, run, force_wr, rd_fire, wr_fire;

  // The RAM-side outputs are combinational so a read accepted this cycle
  // reaches the RAM this cycle and returns data next cycle. They are gated
  // by rst so the RAM sees no access while reset is held.
  assign live      = ~rst;
  assign run       = (state_q == RUN) & live;
  assign force_wr  = (starve_q == SW'(STARVE));
  assign rd_ready  = run & ~force_wr;
  assign wr_ready  = run & ~buf_v_q;
  assign rd_fire   = rd_req & rd_ready;
  assign wr_fire   = wr_req & wr_ready;
  assign init_done = run;
  assign dbg_state = (state_q == RUN);
  assign rd_valid  = rd_valid_q;

  // ram_read_data only reaches rd_data; forwarded data wins on an address hit.
  assign rd_data = rd_valid_q ? (fwd_q ? fwd_data_q : ram_read_data) : '0;

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    buf_v_d        = buf_v_q;
    buf_addr_d     = buf_addr_q;
    buf_data_d     = buf_data_q;
    starve_d       = starve_q;
    rd_valid_d     = rd_fire;
    fwd_d          = rd_fire & buf_v_q & (buf_addr_q == rd_addr);
    fwd_data_d     = buf_data_q;
    ram_chip_en    = 1'b0;
    ram_write_en   = 1'b0;
    ram_addr       = '0;
    ram_write_data = '0;
    if (live) begin
      if (state_q == INIT) begin
        ram_chip_en  = 1'b1;
        ram_write_en = 1'b1;
        ram_addr     = sweep_q;
        if (sweep_q == ADDR'(DEPTH - 1)) state_d = RUN;
        else                             sweep_d = sweep_q + 1'b1;
      end else if (rd_fire) begin
        ram_chip_en = 1'b1;
        ram_addr    = rd_addr;
        // Cannot pass STARVE: at STARVE rd_ready is low and the write issues.
        if (buf_v_q) starve_d = starve_q + 1'b1;
      end else if (buf_v_q) begin
        ram_chip_en    = 1'b1;
        ram_write_en   = 1'b1;
        ram_addr       = buf_addr_q;
        ram_write_data = buf_data_q;
        buf_v_d        = 1'b0;
        starve_d       = '0;
      end
      // Only possible with an empty buffer, so a new write never issues in
      // the cycle it is accepted.
      if (wr_fire) begin
        buf_v_d    = 1'b1;
        buf_addr_d = wr_addr;
        buf_data_d = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      sweep_q    <= '0;
      buf_v_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      buf_v_q    <= buf_v_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      starve_q   <= starve_d;
      rd_valid_q <= rd_valid_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_bpu_ram_ctrl.sv
`timescale 1ns/1ps
module tb_bpu_ram_ctrl;
  localparam int DATA   = 72;
  localparam int ADDR   = 9;
  localparam int DEPTH  = 512;
  localparam int STARVE = 4;
`ifdef BPU_RAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_req = 1'b0;
  logic [ADDR-1:0] rd_addr = '0;
  logic            wr_req = 1'b0;
  logic [ADDR-1:0] wr_addr = '0;
  logic [DATA-1:0] wr_data = '0;
  logic            rd_ready, rd_valid, wr_ready, init_done, dbg_state;
  logic [DATA-1:0] rd_data, ram_write_data;
  logic [DATA-1:0] ram_read_data = '0;
  logic [ADDR-1:0] ram_addr;
  logic            ram_chip_en, ram_write_en;

  always #5 clk = ~clk;

  bpu_ram_ctrl #(.DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_chip_en(ram_chip_en), .ram_write_en(ram_write_en),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .init_done(init_done), .dbg_state(dbg_state)
  );

  function automatic logic [DATA-1:0] seed_val(input int i);
    return {8'(i), 32'(i * 7 + 3), ~32'(i)};
  endfunction

  // Single-port RAM with 1-cycle read latency, pre-seeded with a pattern.
  logic [DATA-1:0] ram_mem [DEPTH];
  logic            ram_seeded = 1'b0;
  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= seed_val(i);
      ram_seeded <= 1'b1;
    end else if (ram_chip_en) begin
      if (ram_write_en) ram_mem[ram_addr] <= ram_write_data;
      else              ram_read_data <= ram_mem[ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: contents of memory as committed, a pending-write
  // queue (capacity 1), a count of lost arbitrations, and a queue of
  // expected read results (exp_q) that each come due one cycle later.
  logic [DATA-1:0] ref_mem [DEPTH];
  bit              m_seeded = 1'b0;
  bit              m_run;
  int              m_sweep;
  int              m_losses;
  logic [ADDR-1:0] pend_addr_q[$];
  logic [DATA-1:0] pend_data_q[$];
  logic [DATA-1:0] exp_q[$];
  bit              m_due;

  always @(negedge clk) begin
    bit              e_rdy, e_wrdy, fire, e_ce, e_we;
    logic [ADDR-1:0] e_addr;
    logic [DATA-1:0] e_wd;
    if (!m_seeded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
      m_seeded = 1'b1;
    end
    if (rst) begin
      chk("rst_rd_valid", DATA'(rd_valid), '0);
      chk("rst_init_done", DATA'(init_done), '0);
      chk("rst_ram_chip_en", DATA'(ram_chip_en), '0);
      chk("rst_ram_write_en", DATA'(ram_write_en), '0);
      chk("rst_ram_addr", DATA'(ram_addr), '0);
      chk("rst_ram_write_data", ram_write_data, '0);
      chk("rst_rd_data", rd_data, '0);
      m_run = !INIT_EN;
      m_sweep = 0;
      m_losses = 0;
      pend_addr_q.delete();
      pend_data_q.delete();
      exp_q.delete();
      m_due = 1'b0;
    end else begin
      e_rdy  = m_run && (m_losses != STARVE);
      e_wrdy = m_run && (pend_addr_q.size() == 0);
      chk("init_done", DATA'(init_done), DATA'(m_run));
      chk("rd_ready", DATA'(rd_ready), DATA'(e_rdy));
      chk("wr_ready", DATA'(wr_ready), DATA'(e_wrdy));
      chk("rd_valid", DATA'(rd_valid), DATA'(m_due));
      if (m_due && exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
      fire   = rd_req && e_rdy;
      e_ce   = 1'b0;
      e_we   = 1'b0;
      e_addr = '0;
      e_wd   = '0;
      if (!m_run) begin
        e_ce = 1'b1; e_we = 1'b1; e_addr = ADDR'(m_sweep);
        ref_mem[m_sweep] = '0;
        if (m_sweep == DEPTH - 1) m_run = 1'b1;
        else m_sweep++;
      end else if (fire) begin
        e_ce = 1'b1; e_addr = rd_addr;
        if (pend_addr_q.size() > 0 && pend_addr_q[0] == rd_addr) exp_q.push_back(pend_data_q[0]);
        else exp_q.push_back(ref_mem[rd_addr]);
        if (pend_addr_q.size() > 0) m_losses++;
      end else if (pend_addr_q.size() > 0) begin
        e_ce = 1'b1; e_we = 1'b1; e_addr = pend_addr_q[0]; e_wd = pend_data_q[0];
        ref_mem[pend_addr_q[0]] = pend_data_q[0];
        void'(pend_addr_q.pop_front());
        void'(pend_data_q.pop_front());
        m_losses = 0;
      end
      chk("ram_chip_en", DATA'(ram_chip_en), DATA'(e_ce));
      chk("ram_write_en", DATA'(ram_write_en), DATA'(e_we));
      if (e_ce) chk("ram_addr", DATA'(ram_addr), DATA'(e_addr));
      if (e_we) chk("ram_write_data", ram_write_data, e_wd);
      if (wr_req && e_wrdy) begin
        pend_addr_q.push_back(wr_addr);
        pend_data_q.push_back(wr_data);
      end
      m_due = fire;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rq, input logic [ADDR-1:0] ra, input logic wq,
                       input logic [ADDR-1:0] wa, input logic [DATA-1:0] wd);
    @(posedge clk); #1;
    rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called right after reset release: walks the sweep (if any) and checks
  // the first operational cycle.
  task automatic wait_ready();
    int cyc, writes;
    bit seen;
    cyc = 0; writes = 0; seen = 1'b0;
    if (INIT_EN) begin
      for (int k = 0; k < DEPTH + 20 && !seen; k++) begin
        look();
        if (k == 0) chk("sweep_starts_at_0", DATA'(ram_addr), '0);
        if (init_done) seen = 1'b1;
        else begin
          cyc++;
          if (ram_chip_en && ram_write_en && ram_write_data == '0) writes++;
        end
      end
      chk("init_seen", DATA'(seen), DATA'(1));
      chk("init_cycles", DATA'(cyc), DATA'(DEPTH));
      chk("init_writes", DATA'(writes), DATA'(DEPTH));
    end else begin
      look();
      chk("noinit_init_done", DATA'(init_done), DATA'(1));
      chk("noinit_rd_ready", DATA'(rd_ready), DATA'(1));
      chk("noinit_no_ram_access", DATA'(ram_chip_en), '0);
    end
  endtask

  task automatic random_phase(input int n);
    logic [DATA-1:0] d;
    int hi;
    for (int c = 0; c < n; c++) begin
      d  = {8'($urandom), $urandom, $urandom};
      hi = (c % 8 == 0) ? DEPTH - 1 : 15;
      drive($urandom_range(0, 99) < 60, ADDR'($urandom_range(0, hi)),
            $urandom_range(0, 99) < 40, ADDR'($urandom_range(0, 15)), d);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  waits;
    bit  acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    if (INIT_EN) begin
      // Interrupt the sweep at address 100, then let it run to completion.
      repeat (100) @(negedge clk);
      look();
      chk("sweep_at_100", DATA'(ram_addr), DATA'(100));
      chk("init_low_mid_sweep", DATA'(init_done), '0);
      do_reset();
    end
    wait_ready();

    // Write addr 5 = 0xAA, read it back two cycles later from the RAM.
    drive(1'b0, '0, 1'b1, 9'd5, 72'hAA);
    idle(1);
    drive(1'b1, 9'd5, 1'b0, '0, '0);
    drive(1'b0, '0, 1'b0, '0, '0);
    look();
    chk("rd5_valid", DATA'(rd_valid), DATA'(1));
    chk("rd5_data", rd_data, 72'hAA);
    idle(2);

    // Starvation: reads held high; write 7 = 0x55 must issue after 4 losses.
    drive(1'b1, 9'd3, 1'b1, 9'd7, 72'h55);
    drive(1'b1, 9'd3, 1'b0, '0, '0);
    drive(1'b1, 9'd7, 1'b0, '0, '0);
    drive(1'b1, 9'd3, 1'b0, '0, '0);
    look();
    chk("fwd7_valid", DATA'(rd_valid), DATA'(1));
    chk("fwd7_data", rd_data, 72'h55);
    drive(1'b1, 9'd3, 1'b0, '0, '0);
    drive(1'b1, 9'd3, 1'b0, '0, '0);
    look();
    chk("starve_rd_ready", DATA'(rd_ready), '0);
    chk("starve_write_en", DATA'(ram_write_en), DATA'(1));
    chk("starve_addr", DATA'(ram_addr), DATA'(7));
    drive(1'b1, 9'd7, 1'b0, '0, '0);
    look();
    chk("starve_released", DATA'(rd_ready), DATA'(1));
    idle(2);

    // Second write offered while the buffer is full must wait, not vanish.
    drive(1'b1, '0, 1'b1, 9'd9, 72'h1234);
    acc = 1'b0; waits = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      drive(1'b1, '0, 1'b1, 9'd10, 72'h5678);
      look();
      if (k == 0) chk("full_wr_ready", DATA'(wr_ready), '0);
      acc = wr_ready;
      if (!acc) waits++;
    end
    chk("second_write_accepted", DATA'(acc), DATA'(1));
    chk("second_write_waits", DATA'(waits), DATA'(5));
    idle(3);
    drive(1'b1, 9'd10, 1'b0, '0, '0);
    drive(1'b1, 9'd9, 1'b0, '0, '0);
    look();
    chk("rd10_data", rd_data, 72'h5678);
    drive(1'b0, '0, 1'b0, '0, '0);
    look();
    chk("rd9_data", rd_data, 72'h1234);

    random_phase(1500);

    // Reset while running with traffic: buffered write is dropped.
    drive(1'b0, '0, 1'b1, 9'd12, 72'hDEAD);
    do_reset();
    wait_ready();
    random_phase(600);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bpu_ram_ctrl.md
BPU_RAM_CTRL -- requirements
Module: bpu_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA, default 72, RAM word width in bits.
REQ-002 SHALL have parameter ADDR, default 9, RAM address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR, number of RAM entries.
REQ-004 SHALL have parameter STARVE, default 4, consecutive lost write arbitrations before the write is forced.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port rd_req, input, 1, lookup read request.
REQ-008 SHALL have port rd_addr, input, ADDR, lookup address.
REQ-009 SHALL have port rd_ready, output, 1, read accepted when rd_req&rd_ready.
REQ-010 SHALL have port rd_valid, output, 1, read data valid, exactly 1 cycle after acceptance.
REQ-011 SHALL have port rd_data, output, DATA, read data.
REQ-012 SHALL have ports wr_req (input, 1), wr_addr (input, ADDR) and wr_data (input, DATA), forming the update write request.
REQ-013 SHALL have port wr_ready, output, 1, write accepted when wr_req&wr_ready.
REQ-014 SHALL have ports ram_addr (output, ADDR), ram_chip_en (output, 1), ram_write_en (output, 1), ram_write_data (output, DATA) and ram_read_data (input, DATA), driving a single-port RAM with 1-cycle read latency.
REQ-015 SHALL have port init_done, output, 1, high once the RAM is cleared and the block is operational.

Function
REQ-016 SHALL implement FSM states INIT and RUN; INIT->RUN when the sweep address equals DEPTH-1 and the final write has been issued; RUN has no exit except reset.
REQ-017 SHALL, in INIT, issue one write of all-zeros per cycle to addresses 0..DEPTH-1 in ascending order, holding rd_ready=0 and wr_ready=0.
REQ-018 SHALL hold a one-entry write buffer; wr_ready = RUN & buffer empty; an accepted write enters the buffer and leaves it only when issued to the RAM.
REQ-019 SHALL, in RUN, issue at most one RAM access per cycle: a read when rd_req is present and the buffer is not forced, otherwise the buffered write if one exists, otherwise no access (ram_chip_en=0).
REQ-020 SHALL drive rd_ready = RUN & ~force; force is asserted when the starvation counter equals STARVE.
REQ-021 SHALL increment the starvation counter each cycle a buffered write loses to a read, and clear it when the write issues.
REQ-022 SHALL assert rd_valid one cycle after an accepted read; rd_data SHALL be ram_read_data, except that when the read address equals a still-buffered write address, rd_data SHALL be the buffered data (forwarding).
REQ-023 SHALL allow a write accepted in cycle N to issue no earlier than cycle N+1.
REQ-024 SHALL produce no combinational path from ram_read_data to any output other than rd_data.

Reset
REQ-025 SHALL, on reset, set state=INIT, sweep address=0, buffer empty, starvation counter=0, rd_valid=0, init_done=0, ram_chip_en=0, ram_write_en=0, and rd_data, ram_addr and ram_write_data to 0.
REQ-026 SHALL, when reset is asserted mid-sweep or in RUN, discard any buffered write and restart the sweep from address 0.

Configuration
REQ-027 SHALL support macro BPU_RAM_INIT_EN: when defined, REQ-016/017 apply; when undefined, reset enters RUN directly, no clearing writes occur, and init_done=1 in the first cycle after reset deasserts.

Verification
REQ-028 SHALL cover: BPU_RAM_INIT_EN defined, DEPTH=512 -> exactly 512 zero writes at addresses 0..511, init_done rises on the next cycle, and every subsequent read returns 0.
REQ-029 SHALL cover: write addr 5 data 0xAA, then read addr 5 two cycles later -> rd_valid 1 cycle after acceptance with rd_data=0xAA from the RAM.
REQ-030 SHALL cover: write addr 7 data 0x55 accepted while rd_req is held high continuously -> the buffered write issues on the cycle the counter reaches 4 with rd_ready=0 that cycle; a read of addr 7 before the write issues returns 0x55 via forwarding.
REQ-031 SHALL cover: write accepted while the buffer is full -> wr_ready=0 until the buffered write issues; the second write is not lost.
REQ-032 SHALL cover: reset asserted at sweep address 100 -> the sweep restarts at address 0 and init_done stays 0 until 512 writes complete.
REQ-033 SHALL cover: BPU_RAM_INIT_EN undefined -> init_done=1 and rd_ready=1 in the first cycle after reset deasserts, with no RAM writes.
